// File: rtl/memmu_point_reader.sv
// MemMU point reader: in-order point-ID to DDR reads, returning unpacked point fields to ExMU.
// Optional out-of-bounds filtering of requests when MEMMU_RD_BOUNDS_CHECK_EN is defined.
module memmu_point_reader #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        i_SYSTEM_clk,
  input  logic        i_SYSTEM_rst,
  input  logic [31:0] i_MonU_MemMU_parameter,
  input  logic [18:0] i_MemMU_P_size,
  input  logic        i_ExMU_readValid,
  input  logic [18:0] i_ExMU_pointReadID,
  output logic        o_MemMU_R_readReady,
  output logic [31:0] o_MemMU_R_memAddress,
  output logic        o_MemMU_R_memValid,
  input  logic        i_MEM_memReady,
  input  logic        i_MEM_rdataValid,
  input  logic [63:0] i_MEM_rdata,
  output logic        o_MemMU_R_pointValid,
  input  logic        i_ExMU_pointReady,
  output logic [18:0] o_MemMU_R_pointID,
  output logic [15:0] o_MemMU_R_distR0,
  output logic [7:0]  o_MemMU_R_reflR0,
  output logic [15:0] o_MemMU_R_distR1,
  output logic [7:0]  o_MemMU_R_reflR1,
  output logic [7:0]  o_MemMU_R_label,
  output logic        o_MemMU_R_error,
  output logic        o_MemMU_R_protoErr,
  output logic        o_MemMU_R_busy
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = PW + 1;

  logic [18:0]   r_tag_id  [MAX_OUTSTANDING];
  logic          r_tag_err [MAX_OUTSTANDING];
  logic [63:0]   r_dat     [MAX_OUTSTANDING];
  logic [PW-1:0] r_tag_wp, r_tag_rp, r_dat_wp, r_dat_rp;
  logic [CW-1:0] r_tag_cnt, r_dat_cnt, r_pend_cnt;
  logic          r_mem_valid;
  logic [31:0]   r_mem_addr;
  logic          r_proto_err;

  logic          w_accept, w_req_err, w_issue, w_rd_push;
  logic          w_head_err, w_point_valid, w_pop_tag, w_pop_dat, w_fields_en;
  logic [63:0]   w_head_data;
  logic          w_unused;

`ifdef MEMMU_RD_BOUNDS_CHECK_EN
  assign w_req_err = (i_ExMU_pointReadID >= i_MemMU_P_size);
  assign w_unused  = ^i_MEM_rdata[63:56];
`else
  assign w_req_err = 1'b0;
  assign w_unused  = ^{i_MEM_rdata[63:56], i_MemMU_P_size};
`endif

  assign o_MemMU_R_readReady = !i_SYSTEM_rst && (r_tag_cnt < CW'(MAX_OUTSTANDING)) &&
                               (!r_mem_valid || i_MEM_memReady);
  assign w_accept  = i_ExMU_readValid && o_MemMU_R_readReady;
  assign w_issue   = r_mem_valid && i_MEM_memReady;
  // Data with no read pending is a protocol violation and is dropped.
  assign w_rd_push = i_MEM_rdataValid && (r_pend_cnt != '0);

  assign w_head_err    = r_tag_err[r_tag_rp];
  assign w_head_data   = r_dat[r_dat_rp];
  assign w_point_valid = (r_tag_cnt != '0) && (w_head_err || (r_dat_cnt != '0));
  assign w_pop_tag     = w_point_valid && i_ExMU_pointReady;
  assign w_pop_dat     = w_pop_tag && !w_head_err;
  assign w_fields_en   = w_point_valid && !w_head_err;

  // Request stage holds its address until memory takes it.
  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst) begin
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
    end else if (w_accept && !w_req_err) begin
      r_mem_valid <= 1'b1;
      r_mem_addr  <= i_MonU_MemMU_parameter + {10'b0, i_ExMU_pointReadID, 3'b000};
    end else if (i_MEM_memReady) begin
      r_mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst) begin
      r_tag_wp    <= '0;
      r_tag_rp    <= '0;
      r_tag_cnt   <= '0;
      r_dat_wp    <= '0;
      r_dat_rp    <= '0;
      r_dat_cnt   <= '0;
      r_pend_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept)  r_tag_wp <= r_tag_wp + PW'(1);
      if (w_pop_tag) r_tag_rp <= r_tag_rp + PW'(1);
      if (w_rd_push) r_dat_wp <= r_dat_wp + PW'(1);
      if (w_pop_dat) r_dat_rp <= r_dat_rp + PW'(1);
      r_tag_cnt  <= r_tag_cnt + CW'(w_accept) - CW'(w_pop_tag);
      r_dat_cnt  <= r_dat_cnt + CW'(w_rd_push) - CW'(w_pop_dat);
      r_pend_cnt <= r_pend_cnt + CW'(w_issue) - CW'(w_rd_push);
      if (i_MEM_rdataValid && (r_pend_cnt == '0)) r_proto_err <= 1'b1;
    end
  end

  // FIFO storage; validity is tracked by the pointers and counts above.
  always_ff @(posedge i_SYSTEM_clk) begin
    if (w_accept) begin
      r_tag_id[r_tag_wp]  <= i_ExMU_pointReadID;
      r_tag_err[r_tag_wp] <= w_req_err;
    end
    if (w_rd_push) r_dat[r_dat_wp] <= i_MEM_rdata;
  end

  assign o_MemMU_R_memValid   = r_mem_valid;
  assign o_MemMU_R_memAddress = r_mem_addr;
  assign o_MemMU_R_pointValid = w_point_valid;
  assign o_MemMU_R_pointID    = w_point_valid ? r_tag_id[r_tag_rp] : 19'd0;
  assign o_MemMU_R_distR0     = w_fields_en ? w_head_data[15:0]  : 16'd0;
  assign o_MemMU_R_reflR0     = w_fields_en ? w_head_data[23:16] : 8'd0;
  assign o_MemMU_R_distR1     = w_fields_en ? w_head_data[39:24] : 16'd0;
  assign o_MemMU_R_reflR1     = w_fields_en ? w_head_data[47:40] : 8'd0;
  assign o_MemMU_R_label      = w_fields_en ? w_head_data[55:48] : 8'd0;
`ifdef MEMMU_RD_BOUNDS_CHECK_EN
  assign o_MemMU_R_error      = w_point_valid && w_head_err;
`else
  assign o_MemMU_R_error      = 1'b0;
`endif
  assign o_MemMU_R_protoErr   = r_proto_err;
  assign o_MemMU_R_busy       = (r_tag_cnt != '0) || r_mem_valid;

endmodule

// File: tb/tb_memmu_point_reader.sv
// Directed bench for memmu_point_reader: vector table plus multi-cycle sequences.
module tb_memmu_point_reader;

`ifdef MEMMU_RD_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] base;
  logic [18:0] p_size;
  logic        rd_valid;
  logic [18:0] rd_id;
  logic        rd_ready;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic        mem_ready;
  logic        rdata_valid;
  logic [63:0] rdata;
  logic        pt_valid;
  logic        pt_ready;
  logic [18:0] pt_id;
  logic [15:0] dist0, dist1;
  logic [7:0]  refl0, refl1, label;
  logic        err, proto_err, busy;

  int n_checks = 0;
  int n_errors = 0;

  memmu_point_reader #(.MAX_OUTSTANDING(4)) dut (
    .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst),
    .i_MonU_MemMU_parameter(base), .i_MemMU_P_size(p_size),
    .i_ExMU_readValid(rd_valid), .i_ExMU_pointReadID(rd_id),
    .o_MemMU_R_readReady(rd_ready), .o_MemMU_R_memAddress(mem_addr),
    .o_MemMU_R_memValid(mem_valid), .i_MEM_memReady(mem_ready),
    .i_MEM_rdataValid(rdata_valid), .i_MEM_rdata(rdata),
    .o_MemMU_R_pointValid(pt_valid), .i_ExMU_pointReady(pt_ready),
    .o_MemMU_R_pointID(pt_id), .o_MemMU_R_distR0(dist0), .o_MemMU_R_reflR0(refl0),
    .o_MemMU_R_distR1(dist1), .o_MemMU_R_reflR1(refl1), .o_MemMU_R_label(label),
    .o_MemMU_R_error(err), .o_MemMU_R_protoErr(proto_err), .o_MemMU_R_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [18:0] id;
    logic [63:0] data;
    logic [31:0] addr;
    logic [15:0] d0;
    logic [7:0]  r0;
    logic [15:0] d1;
    logic [7:0]  r1;
    logic [7:0]  lb;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    logic [31:0] addr_q[$];
    logic [18:0] ids[3];
    logic [18:0] exp_rd[$];
    int n_acc;
    logic [18:0] nid;

    vecs[0] = '{32'h1000_0000, 19'd5,       64'h00AB_1234_56CD_789A, 32'h1000_0028,
                16'h789A, 8'hCD, 16'h3456, 8'h12, 8'hAB};
    vecs[1] = '{32'hFFFF_FFF0, 19'd3,       64'hFF11_2233_4455_6677, 32'h0000_0008,
                16'h6677, 8'h55, 16'h3344, 8'h22, 8'h11};
    vecs[2] = '{32'h0000_0000, 19'h7FFFE,   64'h0102_0304_0506_0708, 32'h003F_FFF0,
                16'h0708, 8'h06, 16'h0405, 8'h03, 8'h02};
    vecs[3] = '{32'h8000_0004, 19'h12345,   64'hDEAD_BEEF_CAFE_F00D, 32'h8009_1A2C,
                16'hF00D, 8'hFE, 16'hEFCA, 8'hBE, 8'hAD};

    rst = 1'b1; base = '0; p_size = 19'h7FFFF; rd_valid = 1'b0; rd_id = '0;
    mem_ready = 1'b0; rdata_valid = 1'b0; rdata = '0; pt_ready = 1'b0;
    tick();
    tick();
    chk("ready_in_reset", 64'(rd_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 64'(rd_ready), 64'd1);
    chk("rst_memValid", 64'(mem_valid), 64'd0);
    chk("rst_memAddress", 64'(mem_addr), 64'd0);
    chk("rst_pointValid", 64'(pt_valid), 64'd0);
    chk("rst_fields", 64'({dist0, refl0, dist1, refl1, label, pt_id}), 64'd0);
    chk("rst_flags", 64'({err, proto_err, busy}), 64'd0);
    tick();

    // Single transactions from the vector table
    for (int v = 0; v < 4; v++) begin
      base = vecs[v].base; rd_id = vecs[v].id; rd_valid = 1'b1;
      chk("vec_readReady", 64'(rd_ready), 64'd1);
      tick();
      rd_valid = 1'b0;
      chk("vec_memValid", 64'(mem_valid), 64'd1);
      chk("vec_memAddress", 64'(mem_addr), 64'(vecs[v].addr));
      chk("vec_busy", 64'(busy), 64'd1);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("vec_memValid_drop", 64'(mem_valid), 64'd0);
      tick();
      tick();
      rdata_valid = 1'b1; rdata = vecs[v].data;
      chk("vec_no_early_point", 64'(pt_valid), 64'd0);
      tick();
      rdata_valid = 1'b0; rdata = '0;
      chk("vec_pointValid", 64'(pt_valid), 64'd1);
      chk("vec_pointID", 64'(pt_id), 64'(vecs[v].id));
      chk("vec_distR0", 64'(dist0), 64'(vecs[v].d0));
      chk("vec_reflR0", 64'(refl0), 64'(vecs[v].r0));
      chk("vec_distR1", 64'(dist1), 64'(vecs[v].d1));
      chk("vec_reflR1", 64'(refl1), 64'(vecs[v].r1));
      chk("vec_label", 64'(label), 64'(vecs[v].lb));
      chk("vec_error", 64'(err), 64'd0);
      pt_ready = 1'b1;
      tick();
      pt_ready = 1'b0;
      chk("vec_pointValid_done", 64'(pt_valid), 64'd0);
      chk("vec_busy_done", 64'(busy), 64'd0);
    end

    // Backpressure on memory: one request blocks the request stage
    base = 32'h2000_0000; rd_id = 19'd9; rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    chk("stall_readReady", 64'(rd_ready), 64'd0);
    mem_ready = 1'b1;
    #1;
    chk("stall_release", 64'(rd_ready), 64'd1);
    tick();
    rdata_valid = 1'b1; rdata = 64'd9;
    tick();
    rdata_valid = 1'b0;
    pt_ready = 1'b1;
    chk("stall_pointID", 64'(pt_id), 64'd9);
    tick();
    pt_ready = 1'b0;

    // Five back-to-back requests: only four fit, the rest waits for a delivery
    n_acc = 0; nid = 19'd11; rd_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rd_id = nid;
      if (rd_ready) begin
        n_acc++;
        nid = nid + 19'd1;
      end
      tick();
    end
    chk("fill_accepted", 64'(n_acc), 64'd4);
    chk("fill_readReady", 64'(rd_ready), 64'd0);
    chk("fill_busy", 64'(busy), 64'd1);
    chk("fill_no_point", 64'(pt_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      rdata_valid = 1'b1; rdata = 64'(11 + k);
      tick();
    end
    rdata_valid = 1'b0;
    tick();
    tick();
    chk("hold_pointValid", 64'(pt_valid), 64'd1);
    chk("hold_pointID", 64'(pt_id), 64'd11);
    chk("hold_distR0", 64'(dist0), 64'd11);
    chk("hold_readReady", 64'(rd_ready), 64'd0);
    rd_valid = 1'b0;
    pt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pointValid", 64'(pt_valid), 64'd1);
      chk("drain_pointID", 64'(pt_id), 64'(11 + k));
      chk("drain_distR0", 64'(dist0), 64'(11 + k));
      tick();
      if (k == 0) chk("drain_readReady", 64'(rd_ready), 64'd1);
    end
    pt_ready = 1'b0;
    chk("drain_empty", 64'(pt_valid), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);

    // Bounds sequence: out-of-range ID bypasses memory only when checking is built in
    p_size = 19'd100; base = 32'h3000_0000;
    ids[0] = 19'd10; ids[1] = 19'd150; ids[2] = 19'd20;
    for (int k = 0; k < 3; k++)
      if (!(BOUNDS && ids[k] >= 19'd100)) exp_rd.push_back(ids[k]);
    rd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd_id = ids[k];
      if (mem_valid) addr_q.push_back(mem_addr);
      tick();
    end
    rd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (mem_valid) addr_q.push_back(mem_addr);
      tick();
    end
    mem_ready = 1'b0;
    chk("bounds_reads", 64'(addr_q.size()), 64'(exp_rd.size()));
    for (int k = 0; k < exp_rd.size() && k < addr_q.size(); k++)
      chk("bounds_addr", 64'(addr_q[k]), 64'(base + {10'b0, exp_rd[k], 3'b000}));
    for (int k = 0; k < exp_rd.size(); k++) begin
      rdata_valid = 1'b1; rdata = 64'(exp_rd[k]);
      tick();
    end
    rdata_valid = 1'b0;
    pt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bounds_pointValid", 64'(pt_valid), 64'd1);
      chk("bounds_pointID", 64'(pt_id), 64'(ids[k]));
      chk("bounds_error", 64'(err), 64'(BOUNDS && ids[k] >= 19'd100));
      chk("bounds_distR0", 64'(dist0),
          (BOUNDS && ids[k] >= 19'd100) ? 64'd0 : 64'(ids[k]));
      tick();
    end
    pt_ready = 1'b0;
    chk("bounds_empty", 64'(busy), 64'd0);

    // Stray read data with nothing pending
    rdata_valid = 1'b1; rdata = 64'hFFFF;
    tick();
    rdata_valid = 1'b0;
    chk("proto_set", 64'(proto_err), 64'd1);
    chk("proto_no_point", 64'(pt_valid), 64'd0);
    tick();
    tick();
    chk("proto_sticky", 64'(proto_err), 64'd1);

    // Reset with two reads outstanding, then late data
    mem_ready = 1'b1; rd_valid = 1'b1; rd_id = 19'd1;
    tick();
    rd_id = 19'd2;
    tick();
    rd_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_pointValid", 64'(pt_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_readReady", 64'(rd_ready), 64'd1);
    chk("mid_rst_protoErr", 64'(proto_err), 64'd0);
    chk("mid_rst_memValid", 64'(mem_valid), 64'd0);
    tick();
    rdata_valid = 1'b1; rdata = 64'h1234;
    tick();
    rdata_valid = 1'b0;
    chk("late_protoErr", 64'(proto_err), 64'd1);
    chk("late_no_point", 64'(pt_valid), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
